// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the access-size helper.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Number of bytes touched by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      SZ_D:    size_bytes = 4'd8;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int WORDSIZE  = 64,
  parameter int ADDR_BITS = 9
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_BITS-1:0] req_addr;
  logic [WORDSIZE-1:0]  req_wdata;
  logic                 rsp_valid;
  logic [WORDSIZE-1:0]  rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one doubleword: load extract/extend and store byte enables.
// DMEM_MISALIGN_ERR_EN: flag misaligned offsets instead of truncating them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] rword,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [7:0]  byte_en,
  output logic [63:0] wshift,
  output logic        misaligned
);

  logic [2:0]  low_mask_s;
  logic [2:0]  eff_off_s;
  logic [5:0]  bit_sh_s;
  logic [63:0] field_s;

  assign low_mask_s = 3'(size_bytes(size) - 4'd1);

`ifdef DMEM_MISALIGN_ERR_EN
  assign eff_off_s  = offset;
  assign misaligned = |(offset & low_mask_s);
`else
  assign eff_off_s  = offset & ~low_mask_s;
  assign misaligned = 1'b0;
`endif

  assign bit_sh_s = {eff_off_s, 3'b000};
  assign field_s  = rword >> bit_sh_s;
  assign wshift   = wdata << bit_sh_s;

  // Size-dependent extension of the extracted field and the matching byte mask.
  always_comb begin
    load_data = field_s;
    byte_en   = 8'h00;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {56'd0, field_s[7:0]} : {{56{field_s[7]}}, field_s[7:0]};
        byte_en   = 8'h01 << eff_off_s;
      end
      SZ_H: begin
        load_data = is_unsigned ? {48'd0, field_s[15:0]} : {{48{field_s[15]}}, field_s[15:0]};
        byte_en   = 8'h03 << eff_off_s;
      end
      SZ_W: begin
        load_data = is_unsigned ? {32'd0, field_s[31:0]} : {{32{field_s[31]}}, field_s[31:0]};
        byte_en   = 8'h0F << eff_off_s;
      end
      default: begin
        load_data = field_s;
        byte_en   = 8'hFF;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY wait, one-cycle response pulse.
// Misaligned-access behaviour selected by DMEM_MISALIGN_ERR_EN (see dmem_lane_align).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WORDSIZE  = 64,
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_BITS = ADDR_BITS - 3;
  localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic                 we_r;
  logic [1:0]           size_r;
  logic                 uns_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic [WORDSIZE-1:0]  wdata_r;
  logic                 ready_r;
  logic                 rsp_valid_r;
  logic [WORDSIZE-1:0]  rdata_r;
  logic                 err_r;

  logic [WORDSIZE-1:0]  mem_r [2**IDX_BITS];

  logic [IDX_BITS-1:0]  idx_s;
  logic [WORDSIZE-1:0]  rword_s;
  logic [WORDSIZE-1:0]  load_s;
  logic [WORDSIZE-1:0]  wsh_s;
  logic [7:0]           be_s;
  logic                 mis_s;
  logic                 accept_s;
  logic                 exec_s;
  logic                 wr_en_s;
  logic [WORDSIZE-1:0]  rdata_nxt_s;

  assign idx_s    = addr_r[ADDR_BITS-1:3];
  assign rword_s  = mem_r[idx_s];
  assign accept_s = (state_r == ST_IDLE) && bus.req_valid && ready_r;
  assign exec_s   = (state_r == ST_WAIT) && (cnt_r == CNT_ZERO);
  // A reset on the execution edge must suppress the write as well.
  assign wr_en_s  = exec_s && we_r && !mis_s && !rst;

  dmem_lane_align u_align (
    .size        (size_r),
    .is_unsigned (uns_r),
    .offset      (addr_r[2:0]),
    .rword       (rword_s),
    .wdata       (wdata_r),
    .load_data   (load_s),
    .byte_en     (be_s),
    .wshift      (wsh_s),
    .misaligned  (mis_s)
  );

  // Response data: stores and rejected accesses return zero.
  always_comb begin
    rdata_nxt_s = {WORDSIZE{1'b0}};
    if (we_r || mis_s) begin
      rdata_nxt_s = {WORDSIZE{1'b0}};
    end else begin
      rdata_nxt_s = load_s;
    end
  end

  // Control FSM, request latches and registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rdata_r     <= {WORDSIZE{1'b0}};
      err_r       <= 1'b0;
      we_r        <= 1'b0;
      size_r      <= SZ_B;
      uns_r       <= 1'b0;
      addr_r      <= {ADDR_BITS{1'b0}};
      wdata_r     <= {WORDSIZE{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (accept_s) begin
            we_r    <= bus.req_we;
            size_r  <= bus.req_size;
            uns_r   <= bus.req_unsigned;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            cnt_r   <= CNT_LOAD;
            ready_r <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (exec_s) begin
            rdata_r     <= rdata_nxt_s;
            err_r       <= mis_s;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array: byte-masked writes, contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wsh_s[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;

endmodule
